piso_serializer: RTL

//   Parallel-in/serial-out stage directly upstream of the serial-in/serial-out shift register.

---
 rtl/piso_serializer_pkg.sv | 13 +
 rtl/ser_bit_counter.sv | 26 ++
 rtl/piso_serializer.sv | 108 ++++++++++
 3 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared serial-link definitions: FSM state encoding reused by the serializer
// and the downstream deserializer.
package piso_serializer_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

endpackage

// File: rtl/ser_bit_counter.sv
// Modulo-N bit counter: clr has priority over en; wraps to 0 after N-1.
module ser_bit_counter #(
  parameter int N  = 8,
  parameter int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          last
);

  assign last = (count == CW'(N - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready load and gapless framing.
// Define PARITY_EN to append an even-parity bit after each data word.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done
);
  import piso_serializer_pkg::*;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef PARITY_EN
  localparam bit PAR = 1'b1;
  logic par;
`else
  localparam bit PAR = 1'b0;
`endif

  state_t         state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]  count;
  logic           last;
  logic           accept;
  logic           load_bit;
  logic           next_bit;
  logic           pre_last;
  logic           frame_end;

  // frame_end marks a cycle in which a new word may be accepted (idle or final bit).
  always_comb begin
    accept    = load_valid & load_ready;
    shifted   = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
    load_bit  = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
    next_bit  = MSB_FIRST ? shifted[WIDTH-1] : shifted[0];
    pre_last  = (count == CW'(WIDTH - 2));
    frame_end = (state == ST_IDLE) || (state == ST_PARITY) ||
                ((state == ST_SHIFT) && last && !PAR);
  end

  ser_bit_counter #(.N(WIDTH), .CW(CW)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (frame_end & accept),
    .en    (state == ST_SHIFT),
    .count (count),
    .last  (last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      ser_out    <= 1'b0;
      ser_valid  <= 1'b0;
      frame_done <= 1'b0;
      load_ready <= 1'b0;
    end else if (frame_end) begin
      if (accept) begin
        state      <= ST_SHIFT;
        shreg      <= load_data;
        ser_out    <= load_bit;
        ser_valid  <= 1'b1;
        frame_done <= 1'b0;
        load_ready <= 1'b0;
      end else begin
        state      <= ST_IDLE;
        ser_out    <= 1'b0;
        ser_valid  <= 1'b0;
        frame_done <= 1'b0;
        load_ready <= 1'b1;
      end
    end else if (!last) begin
      shreg      <= shifted;
      ser_out    <= next_bit;
      frame_done <= pre_last & !PAR;
      load_ready <= pre_last & !PAR;
`ifdef PARITY_EN
    end else begin
      state      <= ST_PARITY;
      ser_out    <= par;
      frame_done <= 1'b1;
      load_ready <= 1'b1;
`endif
    end
  end

`ifdef PARITY_EN
  // par tracks the XOR of all bits shown so far in the current frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par <= 1'b0;
    end else if (frame_end && accept) begin
      par <= load_bit;
    end else if ((state == ST_SHIFT) && !last) begin
      par <= par ^ next_bit;
    end
  end
`endif

endmodule
